// File: rtl/mem_dma_copy_if.sv
// ---------------------------------------------------------------------------
// mem_dma_copy_if
//   Single-word request/ack memory bus between a DMA initiator and a memory
//   responder that signals acceptance with busy and completion with ack.
//
//   Signals:
//     mem_rd_req   initiator -> responder  read request
//     mem_wr_req   initiator -> responder  write request
//     mem_addr     initiator -> responder  word-aligned byte address
//     mem_wr_data  initiator -> responder  write data
//     mem_rd_data  responder -> initiator  read data, valid with mem_ack
//     mem_busy     responder -> initiator  request accepted, in progress
//     mem_ack      responder -> initiator  one-cycle completion pulse
// ---------------------------------------------------------------------------
interface mem_dma_copy_if;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
    logic        mem_busy;
    logic        mem_ack;

    modport master (
        output mem_rd_req, mem_wr_req, mem_addr, mem_wr_data,
        input  mem_rd_data, mem_busy, mem_ack
    );

    modport slave (
        input  mem_rd_req, mem_wr_req, mem_addr, mem_wr_data,
        output mem_rd_data, mem_busy, mem_ack
    );
endinterface

// File: rtl/mem_dma_copy.sv
// ---------------------------------------------------------------------------
// mem_dma_copy
//   Word-copy DMA engine. Copies len 32-bit words from src_addr to dst_addr
//   with alternating single-word reads and writes on a busy/ack memory bus,
//   then pulses done. Every request and wait phase is supervised by a
//   timeout; an expired phase aborts the copy and sets a sticky error.
//
//   Ports:
//     clk, rst     clock and synchronous active-high reset
//     start        begin a copy (only accepted while idle)
//     src_addr     source byte address (bits [1:0] ignored)
//     dst_addr     destination byte address (bits [1:0] ignored)
//     len          number of words to copy
//     active       copy in progress
//     done         one-cycle pulse when the copy finishes or aborts
//     error        timeout abort flag, sticky until next accepted start
//     words_done   words fully written in the current or last copy
//     mem          memory bus, initiator side
// ---------------------------------------------------------------------------
module mem_dma_copy #(
    parameter int TIMEOUT = 64,
    parameter int LEN_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             active,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] words_done,
    mem_dma_copy_if.master   mem
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_WAIT = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [2:0]       state;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [LEN_W-1:0] len_q;
    logic [31:0]      data_q;
    logic [CNT_W-1:0] phase_cnt;

    logic in_phase;
    logic phase_exit;
    logic timeout_hit;

    assign in_phase = (state == RD_REQ) || (state == RD_WAIT) ||
                      (state == WR_REQ) || (state == WR_WAIT);

    // A request phase ends when the responder accepts (busy); a wait phase
    // ends on the completion ack. Ack outside a wait phase is ignored.
    assign phase_exit = (((state == RD_REQ)  || (state == WR_REQ))  && mem.mem_busy) ||
                        (((state == RD_WAIT) || (state == WR_WAIT)) && mem.mem_ack);

    // The counter is 0 in the first cycle of a phase; abort at the edge where
    // it would reach TIMEOUT-1, so a dead phase lasts TIMEOUT-1 cycles.
    assign timeout_hit = (phase_cnt == CNT_W'(TIMEOUT - 2));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            data_q     <= '0;
            phase_cnt  <= '0;
            error      <= 1'b0;
            words_done <= '0;
        end else if (in_phase && !phase_exit) begin
            if (timeout_hit) begin
                error <= 1'b1;
                state <= DONE;
            end else begin
                phase_cnt <= phase_cnt + CNT_W'(1);
            end
        end else begin
            // Every transition starts the next phase from a cleared counter.
            phase_cnt <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q      <= src_addr & 32'hFFFF_FFFC;
                        dst_q      <= dst_addr & 32'hFFFF_FFFC;
                        len_q      <= len;
                        error      <= 1'b0;
                        words_done <= '0;
                        state      <= (len == '0) ? DONE : RD_REQ;
                    end
                end
                RD_REQ:  state <= RD_WAIT;
                RD_WAIT: begin
                    data_q <= mem.mem_rd_data;
                    state  <= WR_REQ;
                end
                WR_REQ:  state <= WR_WAIT;
                WR_WAIT: begin
                    words_done <= words_done + LEN_W'(1);
                    src_q      <= src_q + 32'd4;
                    dst_q      <= dst_q + 32'd4;
                    state      <= (words_done + LEN_W'(1) == len_q) ? DONE : RD_REQ;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path infers
    // a latch.
    always_comb begin
        mem.mem_rd_req  = 1'b0;
        mem.mem_wr_req  = 1'b0;
        mem.mem_addr    = '0;
        mem.mem_wr_data = '0;
        case (state)
            RD_REQ: begin
                mem.mem_rd_req = 1'b1;
                mem.mem_addr   = src_q;
            end
            WR_REQ: begin
                mem.mem_wr_req  = 1'b1;
                mem.mem_addr    = dst_q;
                mem.mem_wr_data = data_q;
            end
            default: ;
        endcase
    end

    assign active = in_phase;
    assign done   = (state == DONE);

endmodule

// File: doc/mem_dma_copy.md
# mem_dma_copy

Word-copy DMA engine that acts as the initiator on the delayed-memory request/ack protocol. Given a source byte address, destination byte address and word count, it issues alternating single-word reads and writes until the block is copied, then pulses `done`. It sits between a control master (core or test harness) and a busy/ack memory responder. It supervises every memory phase with a timeout and reports a sticky error.

## Interface
- `TIMEOUT`, default 64: maximum cycles spent in any single request or wait phase before the copy aborts.
- `LEN_W`, default 16: width of the word-count input and progress counter.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a copy; sampled only in IDLE.
- `src_addr` in 32: source byte address, captured on `start`; bits [1:0] are ignored (forced to 0).
- `dst_addr` in 32: destination byte address, captured on `start`; bits [1:0] are ignored (forced to 0).
- `len` in LEN_W: number of 32-bit words to copy, captured on `start`.
- `active` out 1: high from the cycle after `start` is accepted until `done` is pulsed.
- `done` out 1: one-cycle pulse when the copy finishes or aborts.
- `error` out 1: set on timeout abort; sticky until the next accepted `start` or `rst`.
- `words_done` out LEN_W: count of words fully written in the current or last copy.
- `mem_rd_req` out 1: read request to the responder.
- `mem_wr_req` out 1: write request to the responder.
- `mem_addr` out 32: request byte address; word-aligned.
- `mem_wr_data` out 32: write data.
- `mem_rd_data` in 32: read data; valid in the cycle `mem_ack` is high after a read.
- `mem_busy` in 1: responder has accepted a request and is processing it.
- `mem_ack` in 1: one-cycle completion pulse from the responder.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
- **IDLE:** on `start`:
  - Capture addresses (low 2 bits cleared) and `len`; clear `error` and `words_done`.
  - Go to DONE if `len`==0; otherwise go to RD_REQ.
  - `start` in any other state is ignored.
- **RD_REQ:** drive `mem_rd_req`=1 and `mem_addr`=current src. On `mem_busy`=1, go to RD_WAIT and drop the request in the same edge.
- **RD_WAIT:** on `mem_ack`=1, latch `mem_rd_data` into the data buffer and go to WR_REQ.
- **WR_REQ:** drive `mem_wr_req`=1, `mem_addr`=current dst, `mem_wr_data`=buffer. On `mem_busy`=1, go to WR_WAIT.
- **WR_WAIT:** on `mem_ack`=1:
  - Increment `words_done`.
  - Advance src and dst by 4. Addresses wrap modulo 2^32.
  - Go to DONE if `words_done`+1 == `len`; otherwise go to RD_REQ.
- **DONE:** `done`=1 for exactly one cycle, `active`=0, then return to IDLE.
- Request hold rule: a request is held high until `mem_busy` is seen. This makes requests tolerant of a responder that is stalled for a few cycles by its out-of-band write port.
- `mem_rd_req` and `mem_wr_req` are never asserted together. Both are 0 in every WAIT, IDLE and DONE state.
- Phase timeout: a counter is cleared on entry to each REQ/WAIT state and increments each cycle in that state. When it reaches TIMEOUT-1 without the exit condition:
  - Set `error`=1 and go to DONE.
  - Drop the request in the same edge.
  - `words_done` keeps its value.
- `mem_ack` seen in IDLE, DONE or a REQ state is ignored.

## Timing
- Reset values: `active`=0, `done`=0, `error`=0, `words_done`=0, `mem_rd_req`=0, `mem_wr_req`=0, `mem_addr`=0, `mem_wr_data`=0. State is IDLE.
- Reset mid-copy: all outputs return to reset values at that edge and no further requests are issued. An in-flight responder operation completes unobserved.
- Cycle numbering: edge 0 is the edge that samples `start`.
- `mem_rd_req` is visible after edge 0.
- Against a 4-wait-state responder, each word costs exactly 14 cycles:
  - Responder accepts at edge 1; `mem_busy` is seen at edge 2.
  - `mem_ack` is seen at edge 7; `mem_wr_req` is driven from edge 7.
  - Responder accepts the write at edge 8; the write `mem_ack` is seen at edge 14.
- `done` is high in the cycle after edge 14·`len`. For `len`=0, `done` is high in the cycle after edge 0 and no memory request is made.
- `words_done` updates at the same edge the write ack is sampled.

## Test plan
- Copy `len`=1 from 0x10 to 0x40, source word 0xDEADBEEF, 4-wait responder:
  - mem[0x40>>2] = 0xDEADBEEF.
  - `done` pulses once, after edge 14.
  - `error`=0, `words_done`=1.
- Copy `len`=4 from 0x00 to 0x80 → destination words match source in order; `done` after edge 56; requests never overlap.
- `len`=0 → `done` after edge 0; `mem_rd_req` and `mem_wr_req` stay 0 throughout.
- Responder never asserts `mem_busy`, TIMEOUT=64:
  - `mem_rd_req` is held high for 63 cycles, then drops.
  - `error`=1 and `done` pulses; `words_done`=0.
  - The next `start` clears `error`.
- `rst` asserted during WR_WAIT of word 2 of 4 → all outputs 0 the next cycle, state IDLE; a subsequent `start` with `len`=2 copies correctly.
- `start` re-pulsed mid-copy with different addresses → ignored; the original copy completes unchanged. src 0xFFFFFFFC with `len`=2 → the second read is at address 0x00000000 (wrap).
